hazard_stall_unit: RTL and testbench

- Generates the bubble/stall control consumed by the ID/EX pipeline register's stall input.
- It is the producing end of that stall interface, plus the PC and IF/ID write enables.
- Keeps a shift-register scoreboard of register writes in flight in EX, MEM and WB.
- Stalls decode on a RAW hazard against any in-flight destination and counts stall cycles for profiling.

---
 rtl/hazard_stall_unit.sv | 92 +++++++++
 tb/tb_hazard_stall_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Decode-stage RAW hazard detector: scoreboard of in-flight writes, stall/bubble control, stall profiling.
// Optional HAZARD_FORWARDING_EN: stall only on load-use, otherwise drive forward selects.
module hazard_stall_unit #(
  parameter int unsigned DEPTH     = 3,
  parameter bit          WB_BYPASS = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs_addr_i,
  input  logic             id_rs_used_i,
  input  logic [4:0]       id_rt_addr_i,
  input  logic             id_rt_used_i,
  input  logic [4:0]       id_rd_waddr_i,
  input  logic             id_rd_wena_i,
  input  logic             id_rd_sel_i,
  input  logic             freeze_i,
  output logic             stall_o,
  output logic             pc_wena_o,
  output logic             if_id_wena_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
    logic       is_load;
  } entry_t;

  // sb[0] = EX, sb[1] = MEM, sb[DEPTH-1] = WB
  entry_t     sb [DEPTH];
  logic       rs_ok, rt_ok;
  logic       haz_rs, haz_rt, haz;
  logic [1:0] fwd_a, fwd_b;
  logic       load_ex;

`ifdef HAZARD_FORWARDING_EN
  localparam int unsigned E2 = (DEPTH > 1) ? 1 : 0;
`else
  localparam int unsigned NCHK = WB_BYPASS ? DEPTH - 1 : DEPTH;
`endif

  always_comb begin
    rs_ok  = id_valid_i & id_rs_used_i & (id_rs_addr_i != 5'd0);
    rt_ok  = id_valid_i & id_rt_used_i & (id_rt_addr_i != 5'd0);
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    fwd_a  = 2'd0;
    fwd_b  = 2'd0;
`ifdef HAZARD_FORWARDING_EN
    haz_rs = rs_ok & sb[0].valid & sb[0].is_load & (sb[0].addr == id_rs_addr_i);
    haz_rt = rt_ok & sb[0].valid & sb[0].is_load & (sb[0].addr == id_rt_addr_i);
    // Youngest producer wins: EX/MEM before MEM/WB.
    if (rs_ok && sb[0].valid && !sb[0].is_load && sb[0].addr == id_rs_addr_i)
      fwd_a = 2'd1;
    else if (DEPTH > 1 && rs_ok && sb[E2].valid && sb[E2].addr == id_rs_addr_i)
      fwd_a = 2'd2;
    if (rt_ok && sb[0].valid && !sb[0].is_load && sb[0].addr == id_rt_addr_i)
      fwd_b = 2'd1;
    else if (DEPTH > 1 && rt_ok && sb[E2].valid && sb[E2].addr == id_rt_addr_i)
      fwd_b = 2'd2;
`else
    for (int unsigned k = 0; k < NCHK; k++) begin
      if (sb[k].valid && sb[k].addr == id_rs_addr_i) haz_rs = haz_rs | rs_ok;
      if (sb[k].valid && sb[k].addr == id_rt_addr_i) haz_rt = haz_rt | rt_ok;
    end
`endif
  end

  assign haz          = haz_rs | haz_rt;
  assign stall_o      = haz & ~freeze_i & rst_n_i;
  assign pc_wena_o    = ~haz & ~freeze_i & rst_n_i;
  assign if_id_wena_o = pc_wena_o;
  assign fwd_a_sel_o  = rst_n_i ? fwd_a : 2'd0;
  assign fwd_b_sel_o  = rst_n_i ? fwd_b : 2'd0;
  assign load_ex      = id_valid_i & ~stall_o & id_rd_wena_i & (id_rd_waddr_i != 5'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) sb[k] <= '0;
      stall_cnt_o <= '0;
    end else if (!freeze_i) begin
      sb[0] <= load_ex ? {1'b1, id_rd_waddr_i, id_rd_sel_i} : '0;
      for (int unsigned k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
      if (stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: default instance plus a deep, narrow-counter instance.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n, id_valid, rs_used, rt_used, rd_wena, rd_sel, freeze;
  logic [4:0] rs, rt, rd;

  logic        stall1, pcw1, ifw1, stall2, pcw2, ifw2;
  logic [1:0]  fa1, fb1, fa2, fb2;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
    .id_rs_addr_i(rs), .id_rs_used_i(rs_used), .id_rt_addr_i(rt), .id_rt_used_i(rt_used),
    .id_rd_waddr_i(rd), .id_rd_wena_i(rd_wena), .id_rd_sel_i(rd_sel), .freeze_i(freeze),
    .stall_o(stall1), .pc_wena_o(pcw1), .if_id_wena_o(ifw1),
    .fwd_a_sel_o(fa1), .fwd_b_sel_o(fb1), .stall_cnt_o(cnt1)
  );

  hazard_stall_unit #(.DEPTH(24), .WB_BYPASS(1'b0), .CNT_W(4)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
    .id_rs_addr_i(rs), .id_rs_used_i(rs_used), .id_rt_addr_i(rt), .id_rt_used_i(rt_used),
    .id_rd_waddr_i(rd), .id_rd_wena_i(rd_wena), .id_rd_sel_i(rd_sel), .freeze_i(freeze),
    .stall_o(stall2), .pc_wena_o(pcw2), .if_id_wena_o(ifw2),
    .fwd_a_sel_o(fa2), .fwd_b_sel_o(fb2), .stall_cnt_o(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] a_rs, input logic a_rsu,
                        input logic [4:0] a_rt, input logic a_rtu,
                        input logic [4:0] a_rd, input logic a_we, input logic a_ld);
    id_valid = v; rs = a_rs; rs_used = a_rsu; rt = a_rt; rt_used = a_rtu;
    rd = a_rd; rd_wena = a_we; rd_sel = a_ld;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; idle();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; freeze = 1'b0; idle();

    // Reset and issue
    tick(); tick();
    check("rst_stall", stall1, 0);
    check("rst_pcw", pcw1, 0);
    check("rst_cnt", cnt1, 0);
    check("rst_fa", fa1, 0);
    rst_n = 1'b1;
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    #1;
    check("iss_stall", stall1, 0);
    check("iss_pcw", pcw1, 1);
    check("iss_ifw", ifw1, 1);
    tick();
    check("iss_cnt", cnt1, 0);
    check("iss_e1", {25'd0, dut1.sb[0]}, {25'd0, 1'b1, 5'd3, 1'b0});

    // Register $0 write never creates a hazard
    do_reset();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0);
    tick();
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd7, 1, 0);
    #1;
    check("r0_stall", stall1, 0);
    check("r0_pcw", pcw1, 1);

    // Reset in the middle of a stall
    do_reset();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
    tick();
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    #1;
    check("mrst_pre", stall1, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_low", stall1, 0);
    check("mrst_pcw", pcw1, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mrst_rel", stall1, 0);
    check("mrst_relpcw", pcw1, 1);
    check("mrst_cnt", cnt1, 0);

`ifndef HAZARD_FORWARDING_EN
    // Back-to-back ALU dependence: two stall cycles
    do_reset();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    tick();
    set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    #1;
    check("b2b_s1", stall1, 1);
    check("b2b_pcw1", pcw1, 0);
    check("b2b_fa", fa1, 0);
    tick();
    check("b2b_cnt1", cnt1, 1);
    check("b2b_s2", stall1, 1);
    check("b2b_pcw2", ifw1, 0);
    tick();
    check("b2b_cnt2", cnt1, 2);
    check("b2b_s3", stall1, 0);
    check("b2b_pcw3", pcw1, 1);

    // Freeze during the stall
    do_reset();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    tick();
    set_id(1, 5'd1, 1, 5'd5, 1, 5'd6, 1, 0);
    #1;
    check("frz_s1", stall1, 1);
    tick();
    check("frz_cnt1", cnt1, 1);
    freeze = 1'b1;
    #1;
    check("frz_stall", stall1, 0);
    check("frz_pcw", pcw1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_hold", cnt1, 1);
      check("frz_hstall", stall1, 0);
    end
    freeze = 1'b0;
    #1;
    check("frz_rel", stall1, 1);
    tick();
    check("frz_cnt2", cnt1, 2);
    check("frz_end", stall1, 0);

    // Saturation: one write, dependent reader held in decode
    do_reset();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1);
    tick();
    set_id(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 13) check("sat_mid", cnt2, 14);
    end
    check("sat_stall", stall2, 1);
    check("sat_cnt", cnt2, 15);
`else
    // Load-use: one stall, then MEM/WB forward
    do_reset();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 1);
    tick();
    set_id(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0);
    #1;
    check("lu_s1", stall1, 1);
    check("lu_pcw", pcw1, 0);
    tick();
    check("lu_cnt", cnt1, 1);
    check("lu_s2", stall1, 0);
    check("lu_fa", fa1, 2);
    check("lu_fb", fb1, 2);
    tick();
    // ALU-to-ALU dependence resolved by EX/MEM forward
    set_id(1, 5'd8, 1, 5'd0, 1, 5'd9, 1, 0);
    #1;
    check("alu_stall", stall1, 0);
    check("alu_fa", fa1, 1);
    check("alu_fb", fb1, 0);
    tick();
    check("alu_cnt", cnt1, 1);

    // Saturation: repeated load-use pairs
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_id(1, 5'd1, 0, 5'd0, 0, 5'd9, 1, 1);
      tick();
      set_id(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0);
      tick();
      if (i == 13) check("sat_mid", cnt2, 14);
    end
    check("sat_cnt", cnt2, 15);
`endif

    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
